// File: rtl/mem_stage_unit.sv
// -----------------------------------------------------------------------------
// mem_stage_unit
//
// Memory stage of the pipeline. Takes the EX/MEM buffer produced by the
// execution unit and drives a 16-bit word-addressed data memory. Ordinary
// loads/stores complete in one cycle. 32-bit stack transfers are broken into
// sequenced 16-bit accesses:
//   - CALL/INT push the PC (high word at A, low word at A-1). INT also pushes
//     the flags at A-2.
//   - RET/RTI pop the PC (low word, then high word). RTI first pops the flags.
// Stall holds the upstream stages and the EX/MEM buffer while a sequence is
// running. This module also owns the MEM/WB register and the PC/flags restore
// path.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   Data, Address       EX/MEM store data / PC, and address / stack pointer
//   WB_Address          destination register
//   MR, MW, WB          memory read, memory write, register writeback
//   Stack_PC            transfer is a 32-bit PC (CALL/INT/RET/RTI)
//   Stack_Flags         transfer also carries the flags (INT/RTI)
//   Final_Flags         NF|CF|ZF pushed on INT
//   mem_rdata           memory read data, combinational from mem_addr
//   mem_addr, mem_wdata memory word address and write data
//   mem_we, mem_re      write / read strobes
//   Stall               hold IF/ID/EX and the EX/MEM buffer this cycle
//   WB_Data, WB_Address_Out, WB_Out      registered writeback
//   PC_From_Memory, PC_Load              popped PC and its 1-cycle pulse
//   Flags_From_Memory, Flags_Load        popped flags and their 1-cycle pulse
// -----------------------------------------------------------------------------
module mem_stage_unit #(
    parameter int MEM_AW = 12,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Data,
    input  logic [31:0]       Address,
    input  logic [2:0]        WB_Address,
    input  logic              MR,
    input  logic              MW,
    input  logic              WB,
    input  logic              Stack_PC,
    input  logic              Stack_Flags,
    input  logic [2:0]        Final_Flags,
    input  logic [DW-1:0]     mem_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              Stall,
    output logic [31:0]       WB_Data,
    output logic [2:0]        WB_Address_Out,
    output logic              WB_Out,
    output logic [31:0]       PC_From_Memory,
    output logic              PC_Load,
    output logic [2:0]        Flags_From_Memory,
    output logic              Flags_Load
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PUSH_LO   = 3'd1,
        S_PUSH_FL   = 3'd2,
        S_POP_PC_LO = 3'd3,
        S_POP_PC_HI = 3'd4
    } state_t;

    localparam logic [MEM_AW-1:0] ONE = MEM_AW'(1);
    localparam logic [MEM_AW-1:0] TWO = MEM_AW'(2);

    state_t              state_q, state_d;

    // Transfer context captured while IDLE; only consulted once a sequence
    // has left IDLE, so EX/MEM changes during Stall have no effect.
    logic [31:0]         data_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [2:0]          ff_q;
    logic                sf_q;
    logic [DW-1:0]       lo_q, lo_d;

    logic [31:0]         wb_data_q, wb_data_d;
    logic [2:0]          wb_addr_q, wb_addr_d;
    logic                wb_out_q, wb_out_d;
    logic [31:0]         pc_q, pc_d;
    logic                pc_load_q, pc_load_d;
    logic [2:0]          fl_q, fl_d;
    logic                fl_load_q, fl_load_d;

    logic [MEM_AW-1:0]   live_a;
    logic                is_push;
    logic                is_pop;
    logic                wb_en;
    logic                unused_addr_hi;

    assign live_a         = Address[MEM_AW-1:0];
    assign unused_addr_hi = ^Address[31:MEM_AW];

    // MW has priority: MR together with MW is ignored.
    assign is_push = Stack_PC & MW;
    assign is_pop  = Stack_PC & MR & ~MW;
    // Stack transfers never write a register, whatever WB says.
    assign wb_en   = WB & ~Stack_PC;

    // -------------------------------------------------------------------------
    // Memory interface and Stall (combinational).
    // Reset forces the strobes low even in the middle of a sequence.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        Stall     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (MW) begin
                        mem_we    = 1'b1;
                        mem_addr  = live_a;
                        // A PC push starts with the high word.
                        mem_wdata = Stack_PC ? Data[2*DW-1:DW] : Data[DW-1:0];
                        Stall     = Stack_PC;
                    end else if (MR) begin
                        mem_re   = 1'b1;
                        mem_addr = live_a;
                        Stall    = Stack_PC;
                    end
                end
                S_PUSH_LO: begin
                    mem_we    = 1'b1;
                    mem_addr  = addr_q - ONE;
                    mem_wdata = data_q[DW-1:0];
                    Stall     = sf_q;
                end
                S_PUSH_FL: begin
                    mem_we    = 1'b1;
                    mem_addr  = addr_q - TWO;
                    mem_wdata = {{(DW-3){1'b0}}, ff_q};
                end
                S_POP_PC_LO: begin
                    mem_re   = 1'b1;
                    mem_addr = addr_q + ONE;
                    Stall    = 1'b1;
                end
                S_POP_PC_HI: begin
                    mem_re   = 1'b1;
                    // The flags word (if any) sits below the PC on the stack.
                    mem_addr = addr_q + (sf_q ? TWO : ONE);
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state and next values of the registered outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        wb_out_d  = 1'b0;
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        pc_load_d = 1'b0;
        pc_d      = pc_q;
        fl_load_d = 1'b0;
        fl_d      = fl_q;
        case (state_q)
            S_IDLE: begin
                if (is_push) begin
                    state_d = S_PUSH_LO;
                end else if (is_pop) begin
                    if (Stack_Flags) begin
                        fl_d      = mem_rdata[2:0];
                        fl_load_d = 1'b1;
                        state_d   = S_POP_PC_LO;
                    end else begin
                        lo_d    = mem_rdata;
                        state_d = S_POP_PC_HI;
                    end
                end else if (wb_en) begin
                    wb_out_d  = 1'b1;
                    wb_addr_d = WB_Address;
                    wb_data_d = (MR & ~MW) ? {{(32-DW){1'b0}}, mem_rdata} : Data;
                end
            end
            S_PUSH_LO: begin
                state_d = sf_q ? S_PUSH_FL : S_IDLE;
            end
            S_PUSH_FL: begin
                state_d = S_IDLE;
            end
            S_POP_PC_LO: begin
                lo_d    = mem_rdata;
                state_d = S_POP_PC_HI;
            end
            S_POP_PC_HI: begin
                pc_d      = {mem_rdata, lo_q};
                pc_load_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM state and registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sf_q      <= 1'b0;
            wb_out_q  <= 1'b0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            pc_load_q <= 1'b0;
            pc_q      <= '0;
            fl_load_q <= 1'b0;
            fl_q      <= '0;
        end else begin
            state_q   <= state_d;
            if (state_q == S_IDLE) begin
                sf_q <= Stack_Flags;
            end
            wb_out_q  <= wb_out_d;
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            pc_load_q <= pc_load_d;
            pc_q      <= pc_d;
            fl_load_q <= fl_load_d;
            fl_q      <= fl_d;
        end
    end

    // -------------------------------------------------------------------------
    // Transfer context latches (data path, no reset needed).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        lo_q <= lo_d;
        if (state_q == S_IDLE) begin
            data_q <= Data;
            addr_q <= live_a;
            ff_q   <= Final_Flags;
        end
    end

    assign WB_Data           = wb_data_q;
    assign WB_Address_Out    = wb_addr_q;
    assign WB_Out            = wb_out_q;
    assign PC_From_Memory    = pc_q;
    assign PC_Load           = pc_load_q;
    assign Flags_From_Memory = fl_q;
    assign Flags_Load        = fl_load_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Data, Address;
    logic [2:0]  WB_Address, Final_Flags;
    logic        MR, MW, WB, Stack_PC, Stack_Flags;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we, mem_re, Stall;
    logic [31:0] WB_Data;
    logic [2:0]  WB_Address_Out;
    logic        WB_Out;
    logic [31:0] PC_From_Memory;
    logic        PC_Load;
    logic [2:0]  Flags_From_Memory;
    logic        Flags_Load;

    always #5 clk = ~clk;

    mem_stage_unit #(.MEM_AW(12), .DW(16)) dut (
        .clk(clk), .reset(reset), .Data(Data), .Address(Address),
        .WB_Address(WB_Address), .MR(MR), .MW(MW), .WB(WB),
        .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags), .Final_Flags(Final_Flags),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .Stall(Stall),
        .WB_Data(WB_Data), .WB_Address_Out(WB_Address_Out), .WB_Out(WB_Out),
        .PC_From_Memory(PC_From_Memory), .PC_Load(PC_Load),
        .Flags_From_Memory(Flags_From_Memory), .Flags_Load(Flags_Load)
    );

    // Data memory attached to the DUT, and the reference image the model keeps.
    logic [15:0] tb_mem  [0:4095];
    logic [15:0] ref_mem [0:4095];
    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [34:0] wb_q [$];
    logic [31:0] pc_q [$];
    logic [2:0]  fl_q [$];
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        logic [34:0] e;
        if (mon_en) begin
            if (WB_Out) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
                else begin
                    e = wb_q.pop_front();
                    chk("wb_addr", {29'd0, WB_Address_Out}, {29'd0, e[34:32]});
                    chk("wb_data", WB_Data, e[31:0]);
                end
            end
            if (PC_Load) begin
                if (pc_q.size() == 0) chk("pc_unexpected", 32'd1, 32'd0);
                else chk("pc_value", PC_From_Memory, pc_q.pop_front());
            end
            if (Flags_Load) begin
                if (fl_q.size() == 0) chk("flags_unexpected", 32'd1, 32'd0);
                else chk("flags_value", {29'd0, Flags_From_Memory}, {29'd0, fl_q.pop_front()});
            end
        end
    end

    task automatic drive_idle();
        logic [31:0] r;
        r = $urandom;
        Data = $urandom; Address = $urandom;
        WB_Address = r[2:0]; Final_Flags = r[5:3];
        MR = 1'b0; MW = 1'b0; WB = 1'b0; Stack_PC = 1'b0; Stack_Flags = 1'b0;
    endtask

    task automatic drive_garbage();
        logic [31:0] r;
        r = $urandom;
        Data = $urandom; Address = $urandom;
        WB_Address = r[2:0]; Final_Flags = r[5:3];
        MR = r[6]; MW = r[7]; WB = r[8]; Stack_PC = r[9]; Stack_Flags = r[10];
    endtask

    // Reference model: applies one instruction to the reference image and
    // queues the results the DUT must later produce. Returns cycle count.
    task automatic model(input logic [31:0] d, input logic [31:0] a, input logic [2:0] wa,
                         input logic [2:0] ff, input logic mr, input logic mw, input logic wb,
                         input logic spc, input logic sf, output int lat);
        logic [11:0] A, a_lo, a_hi;
        logic [15:0] w;
        A = a[11:0];
        lat = 1;
        if (mw) begin
            if (spc) begin
                ref_mem[A]         = d[31:16];
                ref_mem[A - 12'd1] = d[15:0];
                if (sf) ref_mem[A - 12'd2] = {13'd0, ff};
                lat = sf ? 3 : 2;
            end else begin
                ref_mem[A] = d[15:0];
                if (wb) wb_q.push_back({wa, d});
            end
        end else if (mr) begin
            if (spc) begin
                if (sf) begin
                    w = ref_mem[A];
                    fl_q.push_back(w[2:0]);
                end
                a_lo = sf ? A + 12'd1 : A;
                a_hi = a_lo + 12'd1;
                pc_q.push_back({ref_mem[a_hi], ref_mem[a_lo]});
                lat = sf ? 3 : 2;
            end else if (wb) begin
                wb_q.push_back({wa, 16'h0000, ref_mem[A]});
            end
        end else if (wb && !spc) begin
            wb_q.push_back({wa, d});
        end
    endtask

    // Issues one instruction and holds it until Stall drops; inputs are
    // scrambled during the stalled cycles. Returns in the last cycle, #1
    // after the negedge, with that cycle's inputs still applied.
    task automatic do_instr(input logic [31:0] d, input logic [31:0] a, input logic [2:0] wa,
                            input logic [2:0] ff, input logic mr, input logic mw, input logic wb,
                            input logic spc, input logic sf);
        int lat, cyc;
        @(negedge clk);
        Data = d; Address = a; WB_Address = wa; Final_Flags = ff;
        MR = mr; MW = mw; WB = wb; Stack_PC = spc; Stack_Flags = sf;
        model(d, a, wa, ff, mr, mw, wb, spc, sf, lat);
        #1;
        cyc = 1;
        while (Stall && cyc < 8) begin
            @(negedge clk);
            drive_garbage();
            #1;
            cyc++;
        end
        chk("latency", cyc, lat);
    endtask

    initial begin
        int lat;
        int diffs;
        int first_bad;
        logic [31:0] r, a;
        logic [11:0] a12;
        logic spc, sf, mr, mw;

        for (int i = 0; i < 4096; i++) begin
            r = $urandom;
            tb_mem[i]  = r[15:0];
            ref_mem[i] = r[15:0];
        end

        // Reset with a push request on the inputs: strobes and outputs stay 0.
        reset = 1'b1;
        drive_idle();
        MW = 1'b1; Stack_PC = 1'b1; Address = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_wb_out", {31'd0, WB_Out}, 32'd0);
        chk("rst_wb_data", WB_Data, 32'd0);
        chk("rst_pc_load", {31'd0, PC_Load}, 32'd0);
        chk("rst_pc", PC_From_Memory, 32'd0);
        chk("rst_flags_load", {31'd0, Flags_Load}, 32'd0);
        reset = 1'b0;
        drive_idle();
        mon_en = 1'b1;

        // STD at 0x20.
        do_instr(32'h0000ABCD, 32'h20, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("std_we", {31'd0, mem_we}, 32'd1);
        chk("std_addr", {20'd0, mem_addr}, 32'h20);
        chk("std_wdata", {16'd0, mem_wdata}, 32'hABCD);
        chk("std_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk); #1;
        chk("std_wb_out", {31'd0, WB_Out}, 32'd0);

        // LDD from 0x20 into R3.
        do_instr(32'h0, 32'h20, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("ldd_wb_out", {31'd0, WB_Out}, 32'd1);
        chk("ldd_wb_data", WB_Data, 32'h0000ABCD);
        chk("ldd_wb_addr", {29'd0, WB_Address_Out}, 32'd3);

        // INT push then RTI pop.
        do_instr(32'h00012345, 32'h3FF, 3'd1, 3'b101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("int_mem_3ff", {16'd0, tb_mem[12'h3FF]}, 32'h0001);
        chk("int_mem_3fe", {16'd0, tb_mem[12'h3FE]}, 32'h2345);
        chk("int_mem_3fd", {16'd0, tb_mem[12'h3FD]}, 32'h0005);
        do_instr(32'h0, 32'h3FD, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("rti_pc_load", {31'd0, PC_Load}, 32'd1);
        chk("rti_pc", PC_From_Memory, 32'h00012345);
        chk("rti_flags", {29'd0, Flags_From_Memory}, 32'd5);

        // CALL push at 0 wraps down; RET pop at 0xFFF wraps up.
        do_instr(32'hCAFE1234, 32'hABC00000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("call_mem_000", {16'd0, tb_mem[12'h000]}, 32'hCAFE);
        chk("call_mem_fff", {16'd0, tb_mem[12'hFFF]}, 32'h1234);
        do_instr(32'h0, 32'h00000FFF, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("ret_pc", PC_From_Memory, 32'hCAFE1234);

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            spc = (r[3:0] < 4'd6);
            sf  = spc & r[4];
            case (r[7:5])
                3'd0, 3'd1, 3'd2: begin mw = 1'b1; mr = 1'b0; end
                3'd3, 3'd4, 3'd5: begin mw = 1'b0; mr = 1'b1; end
                3'd6:             begin mw = 1'b1; mr = 1'b1; end
                default:          begin mw = 1'b0; mr = 1'b0; end
            endcase
            case (r[10:8])
                3'd0:    a12 = 12'h000;
                3'd1:    a12 = 12'h001;
                3'd2:    a12 = 12'hFFF;
                3'd3:    a12 = 12'hFFE;
                default: a12 = 12'($urandom);
            endcase
            a = $urandom;
            a = {a[31:12], a12};
            do_instr($urandom, a, 3'($urandom), 3'($urandom), mr, mw, r[11], spc, sf);
            if (r[13:12] == 2'd0) begin
                @(negedge clk);
                drive_idle();
            end
        end

        // Reset in PUSH_LO: only the high word lands in memory.
        @(negedge clk);
        Data = 32'h11112222; Address = 32'h100; WB_Address = 3'd0; Final_Flags = 3'd3;
        MR = 1'b0; MW = 1'b1; WB = 1'b0; Stack_PC = 1'b1; Stack_Flags = 1'b1;
        ref_mem[12'h100] = 16'h1111;
        #1;
        chk("rpush_stall0", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive_garbage();
        #1;
        chk("rpush_we_in_reset", {31'd0, mem_we}, 32'd0);
        chk("rpush_stall_in_reset", {31'd0, Stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        #1;
        chk("rpush_idle_stall", {31'd0, Stall}, 32'd0);
        chk("rpush_idle_we", {31'd0, mem_we}, 32'd0);
        chk("rpush_wb_out", {31'd0, WB_Out}, 32'd0);
        chk("rpush_wb_data", WB_Data, 32'd0);
        chk("rpush_wb_addr", {29'd0, WB_Address_Out}, 32'd0);
        chk("rpush_pc_load", {31'd0, PC_Load}, 32'd0);
        chk("rpush_pc", PC_From_Memory, 32'd0);
        chk("rpush_flags", {29'd0, Flags_From_Memory}, 32'd0);
        chk("rpush_flags_load", {31'd0, Flags_Load}, 32'd0);

        // Reset in POP_PC_LO: flags already popped, the PC never is.
        @(negedge clk);
        Data = 32'h0; Address = 32'h200; WB_Address = 3'd0; Final_Flags = 3'd0;
        MR = 1'b1; MW = 1'b0; WB = 1'b0; Stack_PC = 1'b1; Stack_Flags = 1'b1;
        r = {16'd0, ref_mem[12'h200]};
        fl_q.push_back(r[2:0]);
        #1;
        chk("rpop_stall0", {31'd0, Stall}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive_garbage();
        #1;
        chk("rpop_re_in_reset", {31'd0, mem_re}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rpop_pc_load", {31'd0, PC_Load}, 32'd0);
        chk("rpop_pc", PC_From_Memory, 32'd0);

        // Drain and compare the final memory image.
        repeat (3) @(negedge clk);
        #1;
        chk("wb_q_empty", wb_q.size(), 32'd0);
        chk("pc_q_empty", pc_q.size(), 32'd0);
        chk("fl_q_empty", fl_q.size(), 32'd0);
        diffs = 0;
        first_bad = -1;
        for (int i = 0; i < 4096; i++) begin
            if (tb_mem[i] !== ref_mem[i]) begin
                if (first_bad < 0) first_bad = i;
                diffs++;
            end
        end
        if (first_bad >= 0)
            $display("first differing word at %03h: dut=%h model=%h", first_bad,
                     tb_mem[first_bad], ref_mem[first_bad]);
        chk("mem_image_diffs", diffs, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
